// File: rtl/axis_frame_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_rr_arbiter
//
// Purpose:
//   Frame-granular round-robin arbiter that shares one AXI-stream frame FIFO
//   input among N_PORTS sources. Once a port is granted it keeps the grant
//   until its tlast beat is accepted, so frames are never interleaved. The
//   beat that was accepted is held in a single registered output stage that
//   drives the FIFO.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   input_axis_tdata         packed source data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   input_axis_tvalid/tlast/tuser  per-port stream sideband
//   input_axis_tready        per-port ready; only the granted port can be high
//   output_axis_*            registered stream towards the frame FIFO
//   grant_valid              high while a frame is granted
//   grant_index              current grant, or the last grant (round-robin pointer)
// ---------------------------------------------------------------------------
module axis_frame_rr_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GRANT_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [N_PORTS-1:0]            input_axis_tvalid,
  output logic [N_PORTS-1:0]            input_axis_tready,
  input  logic [N_PORTS-1:0]            input_axis_tlast,
  input  logic [N_PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  output logic                          grant_valid,
  output logic [GRANT_W-1:0]            grant_index
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_next;
  logic [GRANT_W-1:0]   grant_q, grant_next;

  logic [GRANT_W-1:0]   pick;
  logic                 pick_found;
  int                   idx;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid, sel_last, sel_user;
  logic                  can_load, accept;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1, last_p1, user_p1;

  // Round-robin search: start one past the last grant and wrap, so the port
  // served last has the lowest priority next time.
  always_comb begin
    pick       = grant_q;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(grant_q) + k) % N_PORTS;
      if (!pick_found && input_axis_tvalid[idx]) begin
        pick_found = 1'b1;
        pick       = GRANT_W'(idx);
      end
    end
  end

  // Granted-port mux
  assign sel_data  = input_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_valid = input_axis_tvalid[grant_q];
  assign sel_last  = input_axis_tlast[grant_q];
  assign sel_user  = input_axis_tuser[grant_q];

  // The output register can take a new beat when it is empty or draining.
  assign can_load = ~vld_p1 | output_axis_tready;
  assign accept   = (state == BUSY) & sel_valid & can_load;

  always_comb begin
    input_axis_tready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if ((state == BUSY) && (grant_q == GRANT_W'(i)))
        input_axis_tready[i] = can_load;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_q;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // grant_q is kept on the way back to IDLE as the round-robin pointer
        if (accept && sel_last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= GRANT_W'(N_PORTS - 1);
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
    end
  end

  // ---- stage p1: registered output towards the FIFO ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      user_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      last_p1 <= sel_last;
      user_p1 <= sel_user;
      data_p1 <= sel_data;
    end else if (output_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign output_axis_tdata  = data_p1;
  assign output_axis_tvalid = vld_p1;
  assign output_axis_tlast  = last_p1;
  assign output_axis_tuser  = user_p1;
  assign grant_valid        = (state == BUSY);
  assign grant_index        = grant_q;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_rr_arbiter
//
// Purpose:
//   Directed self-checking bench for axis_frame_rr_arbiter (4 ports, 8-bit).
//   Each source emits frames whose beat data encodes {port, frame, position},
//   so expected output streams can be written down directly.
// ---------------------------------------------------------------------------
module tb_axis_frame_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready, in_last, in_user;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last, out_user;
  logic            grant_valid;
  logic [GW-1:0]   grant_index;

  axis_frame_rr_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .GRANT_W(GW)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .grant_valid        (grant_valid),
    .grant_index        (grant_index)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source state per port
  int   len[N];
  int   frames[N];
  int   fno[N];
  int   pos[N];
  logic en[N];
  logic ulast[N];

  // Observation logs
  logic [9:0] out_log[$];   // {user, last, data}
  int         out_tick[$];
  int         grant_log[$];
  int         tick_no = 0;
  logic       prev_gv = 1'b0;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      logic [1:0] p2, f2;
      logic [3:0] q4;
      p2 = i[1:0];
      f2 = fno[i][1:0];
      q4 = pos[i][3:0];
      in_valid[i]           = en[i] && (fno[i] < frames[i]);
      in_data[i*DW +: DW]   = {p2, f2, q4};
      in_last[i]            = (pos[i] == len[i] - 1);
      in_user[i]            = ulast[i] && (pos[i] == len[i] - 1);
    end
    #1;
  endtask

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      len[i] = 1; frames[i] = 0; fno[i] = 0; pos[i] = 0; en[i] = 1'b1; ulast[i] = 1'b0;
    end
    apply();
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic tick();
    logic [N-1:0] hs;
    logic         ohs;
    #1;
    hs  = in_valid & in_ready;
    ohs = out_valid & out_ready;
    if (ohs) begin
      out_log.push_back({out_user, out_last, out_data});
      out_tick.push_back(tick_no);
    end
    @(posedge clk);
    #1;
    tick_no++;
    if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_index));
    prev_gv = grant_valid;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          pos[i] = 0;
          fno[i]++;
        end
      end
    end
    apply();
  endtask

  task automatic run_until(input int nbeats, input int budget, input string name);
    int n;
    n = 0;
    while (out_log.size() < nbeats && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (out_log.size() < nbeats) begin
      failures++;
      $display("FAIL %s timeout: beats=%0d required=%0d", name, out_log.size(), nbeats);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    src_clear();
    tick();
    tick();
    rst = 1'b0;
    out_log.delete();
    out_tick.delete();
    grant_log.delete();
    prev_gv = 1'b0;
    apply();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_last, out_user, out_data} !== 11'h0) begin
      failures++;
      $display("FAIL reset_out: got v=%b l=%b u=%b d=%h required all 0", out_valid, out_last, out_user, out_data);
    end
    checks++;
    if (grant_valid !== 1'b0 || grant_index !== 2'd3) begin
      failures++;
      $display("FAIL reset_grant: got gv=%b gi=%0d required gv=0 gi=3", grant_valid, grant_index);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready: got %b required 0000", in_ready);
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] exp_d[3];
    exp_d[0] = 8'h80; exp_d[1] = 8'h81; exp_d[2] = 8'h82;
    do_reset();
    len[2] = 3; frames[2] = 1;
    apply();
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd2 || in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant: got gv=%b gi=%0d rdy=%b required gv=1 gi=2 rdy=0100", grant_valid, grant_index, in_ready);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[b] || out_last !== (b == 2)) begin
        failures++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b", b, out_valid, out_data, out_last, exp_d[b], (b == 2));
      end
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got gv=%b required 0", grant_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant_index !== 2'd2) begin
      failures++;
      $display("FAIL single_drain: got v=%b gi=%0d required v=0 gi=2", out_valid, grant_index);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d[12];
    int         exp_g[6];
    int         gi;
    exp_d = '{8'h00, 8'h01, 8'h40, 8'h41, 8'hC0, 8'hC1,
              8'h10, 8'h11, 8'h50, 8'h51, 8'hD0, 8'hD1};
    exp_g = '{0, 1, 3, 0, 1, 3};
    do_reset();
    len[0] = 2; frames[0] = 2;
    len[1] = 2; frames[1] = 2;
    len[3] = 2; frames[3] = 2;
    apply();
    run_until(12, 60, "rr");
    for (int b = 0; b < 12 && b < out_log.size(); b++) begin
      checks++;
      if (out_log[b] !== {1'b0, (b % 2 == 1), exp_d[b]}) begin
        failures++;
        $display("FAIL rr_beat%0d: got %h required %h", b, out_log[b], {1'b0, (b % 2 == 1), exp_d[b]});
      end
    end
    for (int g = 0; g < 6; g++) begin
      gi = (g < grant_log.size()) ? grant_log[g] : -1;
      checks++;
      if (gi !== exp_g[g]) begin
        failures++;
        $display("FAIL rr_grant%0d: got %0d required %0d", g, gi, exp_g[g]);
      end
    end
    // Two beats back-to-back, then one bubble before the next frame.
    for (int b = 1; b < 12 && b < out_tick.size(); b++) begin
      checks++;
      if (out_tick[b] - out_tick[b-1] !== ((b % 2 == 1) ? 1 : 2)) begin
        failures++;
        $display("FAIL rr_spacing%0d: got %0d required %0d", b, out_tick[b] - out_tick[b-1], (b % 2 == 1) ? 1 : 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[4];
    exp_d = '{8'h40, 8'h41, 8'h42, 8'h43};
    do_reset();
    len[1] = 4; frames[1] = 1;
    apply();
    tick();
    tick();
    out_ready = 1'b0;
    apply();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h40 || out_last !== 1'b0 || in_ready[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b d=%h l=%b rdy1=%b required v=1 d=40 l=0 rdy1=0", c, out_valid, out_data, out_last, in_ready[1]);
      end
      tick();
    end
    out_ready = 1'b1;
    apply();
    run_until(4, 20, "bp");
    for (int b = 0; b < 4 && b < out_log.size(); b++) begin
      checks++;
      if (out_log[b] !== {1'b0, (b == 3), exp_d[b]}) begin
        failures++;
        $display("FAIL bp_beat%0d: got %h required %h", b, out_log[b], {1'b0, (b == 3), exp_d[b]});
      end
    end
    repeat (3) tick();
    checks++;
    if (out_log.size() !== 4) begin
      failures++;
      $display("FAIL bp_count: got %0d beats required 4", out_log.size());
    end
  endtask

  task automatic test_source_stall();
    logic [9:0] exp_b[4];
    int         g1;
    exp_b = '{10'h000, 10'h001, 10'h102, 10'h1C0};
    do_reset();
    len[0] = 3; frames[0] = 1;
    len[3] = 1; frames[3] = 1;
    apply();
    tick();
    tick();
    en[0] = 1'b0;
    apply();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (grant_valid !== 1'b1 || grant_index !== 2'd0 || in_ready[3] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got gv=%b gi=%0d rdy3=%b required gv=1 gi=0 rdy3=0", c, grant_valid, grant_index, in_ready[3]);
      end
    end
    en[0] = 1'b1;
    apply();
    run_until(4, 20, "stall");
    for (int b = 0; b < 4 && b < out_log.size(); b++) begin
      checks++;
      if (out_log[b] !== exp_b[b]) begin
        failures++;
        $display("FAIL stall_beat%0d: got %h required %h", b, out_log[b], exp_b[b]);
      end
    end
    g1 = (grant_log.size() > 1) ? grant_log[1] : -1;
    checks++;
    if (g1 !== 3) begin
      failures++;
      $display("FAIL stall_second_grant: got %0d required 3", g1);
    end
    repeat (2) tick();
  endtask

  // Follows test_source_stall without reset: pointer is 3, so port 0 wraps in.
  task automatic test_tuser_wrap();
    int gl;
    checks++;
    if (grant_index !== 2'd3 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pointer: got gi=%0d gv=%b required gi=3 gv=0", grant_index, grant_valid);
    end
    src_clear();
    out_log.delete();
    grant_log.delete();
    len[0] = 2; frames[0] = 1; ulast[0] = 1'b1;
    apply();
    run_until(2, 20, "wrap");
    gl = (grant_log.size() > 0) ? grant_log[0] : -1;
    checks++;
    if (gl !== 0) begin
      failures++;
      $display("FAIL wrap_grant: got %0d required 0", gl);
    end
    checks++;
    if (out_log.size() < 2 || out_log[0] !== 10'h000 || out_log[1] !== 10'h301) begin
      failures++;
      $display("FAIL wrap_tuser: got %h %h required 000 301",
               (out_log.size() > 0) ? out_log[0] : 10'h3FF, (out_log.size() > 1) ? out_log[1] : 10'h3FF);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    len[2] = 5; frames[2] = 1;
    apply();
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      failures++;
      $display("FAIL rstmid_pre: got v=%b d=%h required v=1 d=81", out_valid, out_data);
    end
    rst = 1'b1;
    apply();
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant_valid !== 1'b0 || grant_index !== 2'd3 || in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid: got v=%b gv=%b gi=%0d rdy=%b required v=0 gv=0 gi=3 rdy=0000", out_valid, grant_valid, grant_index, in_ready);
    end
    src_clear();
    rst = 1'b0;
    apply();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    in_user   = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_source_stall();
    test_tuser_wrap();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
